// File: rtl/kernel_cc_fifo_w64_unpack_reader.sv
// Pops 64-bit words from an ap_fifo read port and streams them out
// as two 32-bit elements (low half first), bounded by an element count.
module kernel_cc_fifo_w64_unpack_reader #(
  parameter int ELEM_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_elems,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    words_popped,
  input  logic                fifo_empty_n,
  output logic                fifo_read,
  input  logic [2*ELEM_W-1:0] fifo_dout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ELEM_W-1:0]   out_data,
  output logic                out_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LO,
    S_HI,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_d;
  logic [2*ELEM_W-1:0] word_q;
  logic [2*ELEM_W-1:0] word_d;
  logic [CNT_W-1:0]    rem;
  logic [CNT_W-1:0]    rem_d;
  logic [CNT_W-1:0]    wp_d;
  logic                rem_one;

  assign rem_one = (rem == CNT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      word_q       <= '0;
      rem          <= '0;
      words_popped <= '0;
    end else begin
      state        <= state_d;
      word_q       <= word_d;
      rem          <= rem_d;
      words_popped <= wp_d;
    end
  end

  always_comb begin
    state_d   = state;
    word_d    = word_q;
    rem_d     = rem;
    wp_d      = words_popped;
    busy      = 1'b0;
    done      = 1'b0;
    fifo_read = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          rem_d   = num_elems;
          wp_d    = '0;
          state_d = (num_elems == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        busy      = 1'b1;
        fifo_read = fifo_empty_n;
        if (fifo_empty_n) begin
          word_d  = fifo_dout;
          wp_d    = words_popped + CNT_W'(1);
          state_d = S_LO;
        end
      end
      S_LO: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = word_q[ELEM_W-1:0];
        out_last  = rem_one;
        if (out_ready) begin
          rem_d   = rem - CNT_W'(1);
          state_d = rem_one ? S_DONE : S_HI;
        end
      end
      S_HI: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = word_q[2*ELEM_W-1:ELEM_W];
        out_last  = rem_one;
        if (out_ready) begin
          rem_d = rem - CNT_W'(1);
          if (rem_one) begin
            state_d = S_DONE;
          end else if (fifo_empty_n) begin
            // pop in the same cycle so a full FIFO sustains 1 element/cycle
            fifo_read = 1'b1;
            word_d    = fifo_dout;
            wp_d      = words_popped + CNT_W'(1);
            state_d   = S_LO;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_kernel_cc_fifo_w64_unpack_reader.sv
// Scoreboard bench: FIFO model feeds the reader, a monitor checks the
// element stream against expectations queued by the directed stimulus.
module tb_kernel_cc_fifo_w64_unpack_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] num_elems = '0;
  logic        busy;
  logic        done;
  logic [31:0] words_popped;
  logic        fifo_empty_n = 1'b0;
  logic        fifo_read;
  logic [63:0] fifo_dout = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;

  int errors = 0;
  int checks = 0;

  logic [63:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rp_n;
  int pop_cnt = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } elem_t;
  elem_t exp_q [$];

  kernel_cc_fifo_w64_unpack_reader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .num_elems    (num_elems),
    .busy         (busy),
    .done         (done),
    .words_popped (words_popped),
    .fifo_empty_n (fifo_empty_n),
    .fifo_read    (fifo_read),
    .fifo_dout    (fifo_dout),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ap_fifo model: pop on fifo_read at the clock edge
  always @(posedge clk) begin
    rp_n = rd_ptr + (fifo_read ? 1 : 0);
    rd_ptr <= rp_n;
    pop_cnt <= pop_cnt + (fifo_read ? 1 : 0);
    fifo_empty_n <= (wr_ptr != rp_n);
    fifo_dout <= mem[rp_n % 16];
  end

  // monitor samples just before each rising edge
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  elem_t       e;

  always begin
    @(negedge clk);
    #4;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (fifo_read)
        chk("read_when_empty", {63'd0, fifo_empty_n}, 64'd1);
      if (prev_stall) begin
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_data", {32'd0, out_data}, {32'd0, prev_data});
        chk("stall_last", {63'd0, out_last}, {63'd0, prev_last});
      end
      if (out_valid && !out_ready)
        chk("pop_while_stalled", {63'd0, fifo_read}, 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_elem", {32'd0, out_data}, 64'hdead);
        end else begin
          e = exp_q.pop_front();
          chk("elem_data", {32'd0, out_data}, {32'd0, e.data});
          chk("elem_last", {63'd0, out_last}, {63'd0, e.last});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic push(input logic [63:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr++;
  endtask

  task automatic expect_e(input logic [31:0] d, input logic l);
    exp_q.push_back('{data: d, last: l});
  endtask

  task automatic burst(input int n, input int exp_cyc,
                       input int exp_pops, input bit stall);
    int cyc;
    int p0;
    int k;
    bit pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    k = 0;
    @(negedge clk);
    start = 1'b1;
    num_elems = n;
    p0 = pop_cnt;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      if (stall) begin
        if (out_valid && k < 6) begin
          out_ready = pat[k];
          k++;
        end else begin
          out_ready = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    chk("done_seen", {63'd0, done}, 64'd1);
    if (exp_cyc > 0)
      chk("done_latency", cyc, exp_cyc);
    chk("pops", pop_cnt - p0, exp_pops);
    chk("words_popped", {32'd0, words_popped}, exp_pops);
    chk("elems_left", exp_q.size(), 0);
    @(negedge clk);
    chk("done_pulse", {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_outs", {58'd0, busy, done, fifo_read, out_valid, out_last, 1'b0},
        64'd0);
    chk("rst_data", {out_data, words_popped}, 64'd0);
    reset_n = 1'b1;

    // full burst, even count
    push(64'h22222222_11111111);
    push(64'h44444444_33333333);
    expect_e(32'h11111111, 1'b0);
    expect_e(32'h22222222, 1'b0);
    expect_e(32'h33333333, 1'b0);
    expect_e(32'h44444444, 1'b1);
    burst(4, 6, 2, 1'b0);

    // odd count drops the high half, third word stays queued
    push(64'h22222222_11111111);
    push(64'h44444444_33333333);
    push(64'h66666666_55555555);
    expect_e(32'h11111111, 1'b0);
    expect_e(32'h22222222, 1'b0);
    expect_e(32'h33333333, 1'b1);
    burst(3, 5, 2, 1'b0);
    chk("leftover", wr_ptr - pop_cnt, 1);

    // zero-length burst
    burst(0, 1, 0, 1'b0);

    // backpressure, consuming the leftover word first
    push(64'h88888888_77777777);
    expect_e(32'h55555555, 1'b0);
    expect_e(32'h66666666, 1'b0);
    expect_e(32'h77777777, 1'b0);
    expect_e(32'h88888888, 1'b1);
    burst(4, 0, 2, 1'b1);

    // empty FIFO while fetching; start during busy is ignored
    @(negedge clk);
    start = 1'b1;
    num_elems = 2;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("empty_hold", {61'd0, fifo_read, out_valid, busy}, 64'd1);
      start = (i == 1);
      num_elems = 7;
      @(negedge clk);
    end
    start = 1'b0;
    expect_e(32'h99999999, 1'b0);
    expect_e(32'hAAAAAAAA, 1'b1);
    push(64'hAAAAAAAA_99999999);
    @(negedge clk);
    chk("arrive_read", {62'd0, fifo_read, out_valid}, 64'd2);
    @(negedge clk);
    chk("arrive_valid", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    chk("empty_done", {63'd0, done}, 64'd1);
    chk("empty_wp", {32'd0, words_popped}, 64'd1);
    chk("empty_elems", exp_q.size(), 0);
    @(negedge clk);
    @(negedge clk);
    chk("ignored_start", {62'd0, busy, done}, 64'd0);

    // asynchronous reset while presenting the high half
    push(64'hCCCCCCCC_BBBBBBBB);
    push(64'hEEEEEEEE_DDDDDDDD);
    expect_e(32'hBBBBBBBB, 1'b0);
    expect_e(32'hCCCCCCCC, 1'b0);
    @(negedge clk);
    start = 1'b1;
    num_elems = 4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("in_hi", {32'd0, out_data}, 64'hCCCCCCCC);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_outs", {58'd0, busy, done, fifo_read, out_valid, out_last, 1'b0},
        64'd0);
    chk("arst_data", {out_data, words_popped}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst_idle", {62'd0, busy, done}, 64'd0);

    // clean burst after reset; DDDD/EEEE word is still at the FIFO head
    push(64'h0F0F0F0F_F0F0F0F0);
    expect_e(32'hDDDDDDDD, 1'b0);
    expect_e(32'hEEEEEEEE, 1'b0);
    expect_e(32'hF0F0F0F0, 1'b0);
    expect_e(32'h0F0F0F0F, 1'b1);
    burst(4, 6, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
